if0_pc_gen: RTL and testbench
=============================

Name: if0_pc_gen

Overview:
- IF0 fetch stage: owns the fetch PC and issues instruction-fetch requests to the ICache with a valid/ready handshake.
- Handles branch/exception redirects and load-use stalls.
- Feeds the IF0→IF1 pipeline register with the accepted fetch PC and a valid flag.
- Contains a one-entry skid buffer so that a request accepted during a stall is never lost.

Parameters:
WORD, 32, datapath/PC width in bits
PC_RST, 32'h1c000000, PC value loaded at reset (first fetch address)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
stall_from_Load  in  1  downstream IF0/IF1 register holds this cycle
redirect_valid  in  1  single-cycle redirect pulse from EX/commit
redirect_pc  in  WORD  redirect target
icache_req_ready  in  1  ICache accepts the request this cycle
icache_req_valid  out  1  fetch request valid
icache_req_addr  out  WORD  fetch address, word aligned
IF0_PC_out  out  WORD  PC presented to the IF0/IF1 register
ICache_valid_out  out  1  IF0_PC_out is a live fetch
perf_wait_cnt  out  32  present only with IF0_PERF_CNT_EN

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=PC_RST, state=IDLE; skid_valid, pending_valid and squash all 0.
  - Outputs: icache_req_valid=0, ICache_valid_out=0, IF0_PC_out=PC_RST, icache_req_addr=PC_RST.
- Reset deassertion: one cycle in IDLE with no request, then FETCH.
- Handshake: hs = icache_req_valid & icache_req_ready.
- Address: icache_req_addr = {pc[WORD-1:2],2'b00}. Sequential next PC = pc+4, modulo 2^WORD (0xFFFFFFFC → 0x00000000).
- State FETCH:
  - icache_req_valid = !stall_from_Load & !skid_valid & !redirect_valid.
  - On hs: pc<=pc+4, stay in FETCH; the accepted PC goes out this cycle (see Outputs).
  - If icache_req_valid=1 and ready=0: go to WAIT.
  - If redirect_valid: pc<=redirect_pc; no request is issued this cycle.
- State WAIT:
  - icache_req_valid=1 and the address is held stable every cycle until hs, regardless of stall or redirect.
  - redirect_valid in WAIT (including the hs cycle): set squash; pending_pc<=redirect_pc, pending_valid<=1. A later redirect overwrites pending_pc (latest wins).
  - On hs without squash: pc<=pc+4, go to FETCH.
  - On hs with squash: pc<=pending_pc (or redirect_pc if redirect arrives in the same cycle); clear pending and squash; the accepted fetch is discarded (never presented valid); go to FETCH.
- Outputs to IF0/IF1 (combinational):
  - IF0_PC_out = skid_valid ? skid_pc : icache_req_addr.
  - ICache_valid_out = skid_valid | (hs & !squash & !redirect_valid).
- Skid buffer:
  - Fill: hs while stall_from_Load=1 and not squashed → skid_valid<=1, skid_pc<=icache_req_addr. This can only happen in WAIT.
  - Drain: cleared on the first cycle with stall_from_Load=0, when the IF0/IF1 register latches it.
  - Redirect while skid_valid: skid_valid<=0 (squashed).
- Latency: address to IF0_PC_out is 0 cycles on hs; a redirect in FETCH gives its first request on the next cycle.
- Redirect vs stall: redirect has priority over stall for PC update; stall never blocks pc<=redirect_pc.

Optional Feature:
- Macro IF0_PERF_CNT_EN.
- Defined:
  - perf_wait_cnt port exists.
  - 32-bit counter increments each cycle with icache_req_valid & !icache_req_ready.
  - Saturates at 0xFFFFFFFF; reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then ready held 1, no stall → requests 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles starting the 2nd cycle after release; ICache_valid_out=1 each cycle.
- ready=0 for 3 cycles at 0x1c000004 → icache_req_addr stays 0x1c000004 for 4 cycles; one valid output on the hs cycle; perf_wait_cnt=3 with IF0_PERF_CNT_EN.
- redirect_valid to 0x1c000100 while in WAIT at 0x1c000008, ready 2 cycles later → 0x1c000008 never presented valid; next request is 0x1c000100.
- stall_from_Load=1 while in WAIT, hs occurs → skid holds 0x1c00000c; no new request during stall; stall drop → IF0_PC_out=0x1c00000c, valid=1 for one cycle, then fetch resumes at 0x1c000010.
- redirect to 0xFFFFFFFC, ready=1 → next fetches 0xFFFFFFFC, 0x00000000 (wrap).
- rst asserted mid-WAIT → icache_req_valid=0 immediately (asynchronous); after release fetch restarts at PC_RST.

Source files
------------

// File: rtl/if0_pc_gen.sv
// IF0 fetch-PC generator: issues ICache requests, handles redirects, stalls and a one-entry skid.
// Optional `IF0_PERF_CNT_EN adds perf_wait_cnt (cycles a request waits on the ICache).
module if0_pc_gen #(
    parameter int              WORD   = 32,
    parameter logic [WORD-1:0] PC_RST = 32'h1c000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_from_Load,
    input  logic            redirect_valid,
    input  logic [WORD-1:0] redirect_pc,
    input  logic            icache_req_ready,
    output logic            icache_req_valid,
    output logic [WORD-1:0] icache_req_addr,
    output logic [WORD-1:0] IF0_PC_out,
    output logic            ICache_valid_out
`ifdef IF0_PERF_CNT_EN
    ,
    output logic [31:0]     perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

    state_t          state_q;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] skid_pc_q, pending_pc_q;
    logic            skid_valid_q, pending_valid_q, squash_q;
    logic            hs, kill;

    assign icache_req_addr = {pc_q[WORD-1:2], 2'b00};

    always_comb begin
        icache_req_valid = 1'b0;
        unique case (state_q)
            S_FETCH: icache_req_valid = !stall_from_Load & !skid_valid_q & !redirect_valid;
            S_WAIT:  icache_req_valid = 1'b1;
            default: icache_req_valid = 1'b0;
        endcase
    end

    assign hs   = icache_req_valid & icache_req_ready;
    // An accepted fetch is dead if a redirect is pending or arrives with it.
    assign kill = squash_q | redirect_valid;

    assign ICache_valid_out = skid_valid_q | (hs & !kill);
    assign IF0_PC_out       = skid_valid_q ? skid_pc_q : icache_req_addr;

    always_comb begin
        pc_d = pc_q;
        unique case (state_q)
            S_IDLE:  if (redirect_valid) pc_d = redirect_pc;
            S_FETCH: begin
                if (redirect_valid) pc_d = redirect_pc;
                else if (hs)        pc_d = pc_q + WORD'(4);
            end
            S_WAIT: begin
                if (hs) begin
                    if (redirect_valid)       pc_d = redirect_pc;
                    else if (pending_valid_q) pc_d = pending_pc_q;
                    else                      pc_d = pc_q + WORD'(4);
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            pc_q            <= PC_RST;
            skid_valid_q    <= 1'b0;
            skid_pc_q       <= '0;
            pending_valid_q <= 1'b0;
            pending_pc_q    <= '0;
            squash_q        <= 1'b0;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                S_IDLE:  state_q <= S_FETCH;
                S_FETCH: if (icache_req_valid && !icache_req_ready) state_q <= S_WAIT;
                S_WAIT: begin
                    // Address must stay stable until accepted, so a redirect is parked.
                    if (redirect_valid) begin
                        squash_q        <= 1'b1;
                        pending_valid_q <= 1'b1;
                        pending_pc_q    <= redirect_pc;
                    end
                    if (hs) begin
                        state_q         <= S_FETCH;
                        squash_q        <= 1'b0;
                        pending_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (skid_valid_q && (!stall_from_Load || redirect_valid)) begin
                skid_valid_q <= 1'b0;
            end else if (hs && stall_from_Load && !kill) begin
                skid_valid_q <= 1'b1;
                skid_pc_q    <= icache_req_addr;
            end
        end
    end

`ifdef IF0_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_wait_cnt <= '0;
        else if (icache_req_valid && !icache_req_ready && perf_wait_cnt != 32'hFFFF_FFFF)
            perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_if0_pc_gen.sv
// Bench for if0_pc_gen: directed vector table, async-reset sequence, random run against a cycle model.
module tb_if0_pc_gen;
    localparam logic [31:0] B = 32'h1c000000;

    logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, rv = 1'b0, rdy = 1'b0;
    logic [31:0] rpc = '0;
    logic        req_valid, out_valid;
    logic [31:0] req_addr, pc_out;
`ifdef IF0_PERF_CNT_EN
    logic [31:0] perf;
`endif

    always #5 clk = ~clk;

    if0_pc_gen #(.WORD(32), .PC_RST(B)) dut (
        .clk(clk), .rst(rst), .stall_from_Load(stall), .redirect_valid(rv),
        .redirect_pc(rpc), .icache_req_ready(rdy), .icache_req_valid(req_valid),
        .icache_req_addr(req_addr), .IF0_PC_out(pc_out), .ICache_valid_out(out_valid)
`ifdef IF0_PERF_CNT_EN
        , .perf_wait_cnt(perf)
`endif
    );

    typedef struct {
        logic        st, rv, rdy;
        logic [31:0] rpc;
        logic        ereq, eov;
        logic [31:0] eaddr, epo;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0, fails = 0;

    function automatic vec_t v(input logic s, input logic r, input logic [31:0] p, input logic y,
                               input logic eq, input logic [31:0] ea, input logic eo,
                               input logic [31:0] ep);
        vec_t t;
        t.st = s; t.rv = r; t.rpc = p; t.rdy = y;
        t.ereq = eq; t.eaddr = ea; t.eov = eo; t.epo = ep;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] p, input logic y);
        stall = s; rv = r; rpc = p; rdy = y;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_valid", 32'(req_valid), 0);
        chk("rst req_addr", req_addr, B);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst pc_out", pc_out, B);
`ifdef IF0_PERF_CNT_EN
        chk("rst perf", perf, 0);
`endif
        rst = 1'b1;
    endtask

    // Behavioural model state
    bit          m_started, m_out, m_kill;
    logic [31:0] m_pc, m_kill_pc, m_wait;
    logic [31:0] m_skid[$];

    initial begin
        // row: stall, redir, redir_pc, ready | req, addr, out_valid, pc_out
        tbl.push_back(v(0,0,0,1,          0,B,0,B));
        tbl.push_back(v(0,0,0,1,          1,B,1,B));
        tbl.push_back(v(0,0,0,0,          1,B+4,0,B+4));
        tbl.push_back(v(0,0,0,0,          1,B+4,0,B+4));
        tbl.push_back(v(0,0,0,0,          1,B+4,0,B+4));
        tbl.push_back(v(0,0,0,1,          1,B+4,1,B+4));
        tbl.push_back(v(0,0,0,0,          1,B+8,0,B+8));
        tbl.push_back(v(0,1,B+'h100,0,    1,B+8,0,B+8));
        tbl.push_back(v(0,0,0,0,          1,B+8,0,B+8));
        tbl.push_back(v(0,0,0,1,          1,B+8,0,B+8));
        tbl.push_back(v(0,0,0,1,          1,B+'h100,1,B+'h100));
        tbl.push_back(v(0,0,0,0,          1,B+'h104,0,B+'h104));
        tbl.push_back(v(1,0,0,0,          1,B+'h104,0,B+'h104));
        tbl.push_back(v(1,0,0,1,          1,B+'h104,1,B+'h104));
        tbl.push_back(v(1,0,0,1,          0,B+'h108,1,B+'h104));
        tbl.push_back(v(0,0,0,1,          0,B+'h108,1,B+'h104));
        tbl.push_back(v(0,0,0,1,          1,B+'h108,1,B+'h108));
        tbl.push_back(v(0,1,32'hFFFFFFFC,1, 0,B+'h10c,0,B+'h10c));
        tbl.push_back(v(0,0,0,1,          1,32'hFFFFFFFC,1,32'hFFFFFFFC));
        tbl.push_back(v(0,0,0,1,          1,0,1,0));
        tbl.push_back(v(1,0,0,1,          0,4,0,4));
        tbl.push_back(v(0,0,0,0,          1,4,0,4));
        tbl.push_back(v(0,1,B+'h200,1,    1,4,0,4));
        tbl.push_back(v(0,0,0,1,          1,B+'h200,1,B+'h200));
        tbl.push_back(v(0,0,0,0,          1,B+'h204,0,B+'h204));
        tbl.push_back(v(0,1,B+'h300,0,    1,B+'h204,0,B+'h204));
        tbl.push_back(v(0,1,B+'h400,0,    1,B+'h204,0,B+'h204));
        tbl.push_back(v(0,0,0,1,          1,B+'h204,0,B+'h204));
        tbl.push_back(v(0,0,0,1,          1,B+'h400,1,B+'h400));
        tbl.push_back(v(0,0,0,0,          1,B+'h404,0,B+'h404));
        tbl.push_back(v(1,0,0,1,          1,B+'h404,1,B+'h404));
        tbl.push_back(v(1,1,B+'h500,1,    0,B+'h408,1,B+'h404));
        tbl.push_back(v(0,0,0,1,          1,B+'h500,1,B+'h500));

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("row%0d req_valid", i), 32'(req_valid), 32'(tbl[i].ereq));
            chk($sformatf("row%0d req_addr", i), req_addr, tbl[i].eaddr);
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("row%0d pc_out", i), pc_out, tbl[i].epo);
            @(posedge clk);
            #1;
`ifdef IF0_PERF_CNT_EN
            if (i == 5) chk("perf after 3 wait cycles", perf, 3);
`endif
        end

        // Asynchronous reset while a request is stuck in the wait state
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("preWAIT req_addr", req_addr, B + 'h504);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async rst req_valid", 32'(req_valid), 0);
        chk("async rst req_addr", req_addr, B);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk("post-rst idle req_valid", 32'(req_valid), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post-rst first req_valid", 32'(req_valid), 1);
        chk("post-rst first req_addr", req_addr, B);
        chk("post-rst first out_valid", 32'(out_valid), 1);

        // Randomized run against the cycle model
        @(posedge clk);
        do_reset();
        m_started = 0; m_out = 0; m_kill = 0; m_pc = B; m_kill_pc = '0; m_wait = '0;
        m_skid.delete();
        for (int n = 0; n < 3000; n++) begin
            logic        s, r, y, e_req, acc, dead, e_ov;
            logic [31:0] p, e_addr, e_po;
            s = ($urandom_range(0, 3) == 0);
            y = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 11) == 0);
            p = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
            drive(s, r, p, y);

            e_addr = m_pc & ~32'h3;
            if (!m_started)  e_req = 0;
            else if (m_out)  e_req = 1;
            else             e_req = !s && (m_skid.size() == 0) && !r;
            acc  = e_req && y;
            dead = m_kill || r;
            e_ov = (m_skid.size() != 0) || (acc && !dead);
            e_po = (m_skid.size() != 0) ? m_skid[0] : e_addr;

            @(negedge clk);
            chk($sformatf("rnd%0d req_valid", n), 32'(req_valid), 32'(e_req));
            chk($sformatf("rnd%0d req_addr", n), req_addr, e_addr);
            chk($sformatf("rnd%0d out_valid", n), 32'(out_valid), 32'(e_ov));
            chk($sformatf("rnd%0d pc_out", n), pc_out, e_po);
            @(posedge clk);
            #1;

            if (e_req && !y && m_wait != 32'hFFFFFFFF) m_wait = m_wait + 1;
            if (m_skid.size() != 0 && (!s || r)) m_skid.delete();
            if (!m_started) begin
                m_started = 1;
                if (r) m_pc = p;
            end else if (m_out) begin
                if (r) begin m_kill = 1; m_kill_pc = p; end
                if (acc) begin
                    if (!dead && s) m_skid.push_back(e_addr);
                    m_pc   = m_kill ? m_kill_pc : m_pc + 4;
                    m_kill = 0;
                    m_out  = 0;
                end
            end else begin
                if (r)          m_pc = p;
                else if (acc)   m_pc = m_pc + 4;
                else if (e_req) m_out = 1;
            end
        end
`ifdef IF0_PERF_CNT_EN
        chk("rnd perf_wait_cnt", perf, m_wait);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
